// File: rtl/dff_en_pkg.sv
// Shared fixed-point definitions for the backpropagation datapath.
// A word is 1 sign bit, FP_I integer bits and FP_F fraction bits.
package dff_en_pkg;

  localparam int FP_F = 24;
  localparam int FP_I = 7;
  localparam int FP_N = FP_I + FP_F + 1;

  typedef logic [FP_N-1:0] fp_word_t;

  // Raw encoding of +1.0 in the shared fixed-point format.
  function automatic fp_word_t fp_one();
    fp_word_t one;
    one = '0;
    one[FP_F] = 1'b1;
    return one;
  endfunction

endpackage

// File: rtl/dff_en_if.sv
// Load bus of an enable register: enable and next value in, registered value out.
// Parents that build register arrays can carry en/d/q as one bundle.
interface dff_en_if
  import dff_en_pkg::*;
#(
  parameter int N = FP_N
);

  logic         en;
  logic [N-1:0] d;
  logic [N-1:0] q;

  // The side that produces d/en and consumes q.
  modport master (output en, output d, input q);

  // The register itself.
  modport slave (input en, input d, output q);

endinterface

// File: rtl/dff_en.sv
// Enable flip-flop register holding one fixed-point word.
// Pure storage: d is transferred to q bit-exactly, with no arithmetic,
// so q comes straight from flops and external feedback (d = q + x) is safe.
// Ports stay flat and in the order clk, rst, en, d, q because existing
// instances connect by position.
module dff_en
  import dff_en_pkg::*;
#(
  parameter int           N       = FP_N,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Synchronous clear has priority over load; otherwise hold.
  // NOTE: non-blocking assignment so every register samples pre-edge values,
  // which is what keeps the external q -> adder -> d loop race-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_dff_en.sv
// Self-checking bench for dff_en: two instances (zero and non-zero reset value)
// share the same control stimulus; each can run in external-feedback mode
// where d = q + inc. Expected values come from a reference model and go
// through a scoreboard queue that is drained after each clock edge.
module tb_dff_en;
  import dff_en_pkg::*;

  localparam int           N   = FP_N;
  localparam logic [N-1:0] RV1 = 32'hFF00_0000;

  typedef struct {
    string        tag;
    logic [N-1:0] exp0;
    logic [N-1:0] exp1;
  } sb_item_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         fb;
  logic [N-1:0] d_drv;
  logic [N-1:0] inc;

  logic [N-1:0] model0;
  logic [N-1:0] model1;
  sb_item_t     sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dff_en_if #(.N(N)) bus0 ();
  dff_en_if #(.N(N)) bus1 ();

  // Each DUT either takes the driven word or its own q plus an increment.
  assign bus0.en = en;
  assign bus1.en = en;
  assign bus0.d  = fb ? bus0.q + inc : d_drv;
  assign bus1.d  = fb ? bus1.q + inc : d_drv;

  dff_en #(.N(N)) dut0 (
    .clk (clk),
    .rst (rst),
    .en  (bus0.en),
    .d   (bus0.d),
    .q   (bus0.q)
  );

  dff_en #(.N(N), .RST_VAL(RV1)) dut1 (
    .clk (clk),
    .rst (rst),
    .en  (bus1.en),
    .d   (bus1.d),
    .q   (bus1.q)
  );

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] model_next(input logic [N-1:0] cur, input logic [N-1:0] rv,
                                              input logic r, input logic e, input logic f,
                                              input logic [N-1:0] dv, input logic [N-1:0] iv);
    if (r)      return rv;
    else if (e) return f ? cur + iv : dv;
    else        return cur;
  endfunction

  // Drive one cycle of stimulus at the falling edge, queue the model's
  // prediction, then compare both DUTs just after the rising edge.
  task automatic step(input string tag, input logic r, input logic e,
                      input logic [N-1:0] dv, input logic f = 1'b0,
                      input logic [N-1:0] iv = '0);
    sb_item_t item;
    @(negedge clk);
    rst = r; en = e; d_drv = dv; fb = f; inc = iv;
    model0 = model_next(model0, '0,  r, e, f, dv, iv);
    model1 = model_next(model1, RV1, r, e, f, dv, iv);
    item.tag = tag; item.exp0 = model0; item.exp1 = model1;
    sb_q.push_back(item);
    @(posedge clk);
    #1;
    item = sb_q.pop_front();
    check({item.tag, "/rv0"}, bus0.q, item.exp0);
    check({item.tag, "/rv1"}, bus1.q, item.exp1);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; fb = 1'b0; d_drv = '0; inc = '0;
    model0 = 'x; model1 = 'x;

    // Reset wins over a pending load, and holds while rst stays high.
    step("rst_first", 1, 1, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) step("rst_hold", 1, 1, 32'hDEAD_BEEF);

    // Release reset with en low: reset value must hold.
    step("rst_release_hold", 0, 0, 32'h1357_9BDF);

    // Load, then hold against an all-ones d for four edges.
    step("load", 0, 1, 32'h0019_9999);
    for (int i = 0; i < 4; i++) step("hold", 0, 0, 32'hFFFF_FFFF);

    // Reset priority over a simultaneous load.
    step("load_pre_rst", 0, 1, 32'h1234_5678);
    step("rst_vs_en", 1, 1, 32'hAAAA_AAAA);

    // Accumulate +1.0 five times from reset through the external adder.
    for (int i = 0; i < 5; i++) step("acc_one", 0, 1, '0, 1, fp_one());

    // Raw wrap past the most positive value, then a negative load.
    step("load_max", 0, 1, 32'h7FFF_FFFF);
    step("wrap", 0, 1, '0, 1, 32'h0000_0001);
    step("load_neg", 0, 1, 32'hFF00_0000);

    // Enable toggling each cycle with a fresh d each time.
    for (int i = 0; i < 6; i++) step("toggle", 0, logic'(i % 2 == 0), 32'h0F0F_0000 + N'(i));

    // Reset in the middle of an accumulation discards the running sum.
    step("acc_pre_rst", 0, 1, '0, 1, 32'h0080_0000);
    step("acc_pre_rst", 0, 1, '0, 1, 32'h0080_0000);
    step("rst_mid_acc", 1, 1, '0, 1, 32'h0080_0000);
    step("acc_after_rst", 0, 1, '0, 1, 32'h0080_0000);

    check("sb_empty", N'(sb_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
